// File: rtl/adc_soc_frame_unpack.sv
// adc_soc_frame_unpack
// Registered unpacker for one ADC frame. Word 0 is the STATUS word and passes
// through untouched. Words 1..8 carry CH0..CH7, each sample held in the low
// BITS_PER_WORD bits and sign-extended to 32 bits. Any words past index 8 are
// spare and never reach an output. One cycle of latency, no backpressure.

module adc_soc_frame_unpack #(
    parameter int BITS_PER_WORD   = 24,
    parameter int WORDS_PER_FRAME = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_valid,
    input  logic [32*WORDS_PER_FRAME-1:0] frame_words_packed,
    output logic                         out_valid,
    output logic [31:0]                  status_word,
    output logic [31:0]                  ch0,
    output logic [31:0]                  ch1,
    output logic [31:0]                  ch2,
    output logic [31:0]                  ch3,
    output logic [31:0]                  ch4,
    output logic [31:0]                  ch5,
    output logic [31:0]                  ch6,
    output logic [31:0]                  ch7
);

    localparam int NUM_CH = 8;
    // Unused upper bits of a channel word. Shifting the sample up to bit 31 and
    // arithmetic-shifting it back down both discards them and replicates the
    // sample's sign bit. PAD = 0 (32-bit samples) degenerates to a pass-through.
    localparam int PAD = 32 - BITS_PER_WORD;

    // Reject parameter combinations the unpacker cannot represent.
    if (WORDS_PER_FRAME < 9) begin : g_bad_words_per_frame
        $error("adc_soc_frame_unpack: WORDS_PER_FRAME must be >= 9");
    end
    if (BITS_PER_WORD < 2 || BITS_PER_WORD > 32) begin : g_bad_bits_per_word
        $error("adc_soc_frame_unpack: BITS_PER_WORD must be within 2..32");
    end

    logic [31:0] status_d;
    logic [31:0] status_q;
    logic [31:0] ch_d [NUM_CH];
    logic [31:0] ch_q [NUM_CH];
    logic        valid_q;

    // Slice the frame and sign-extend every channel sample.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path; a missed
        // assignment would infer a latch instead of plain wiring.
        status_d = frame_words_packed[31:0];
        for (int i = 0; i < NUM_CH; i++) begin
            ch_d[i] = $signed(frame_words_packed[32*(i+1) +: 32] << PAD) >>> PAD;
        end
    end

    // Capture a frame when valid, otherwise hold; out_valid follows frame_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            status_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments for all state, so every register
            // samples the pre-edge values regardless of statement order.
            valid_q <= frame_valid;
            if (frame_valid) begin
                status_q <= status_d;
                for (int i = 0; i < NUM_CH; i++) begin
                    ch_q[i] <= ch_d[i];
                end
            end
        end
    end

    assign out_valid   = valid_q;
    assign status_word = status_q;
    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign ch4         = ch_q[4];
    assign ch5         = ch_q[5];
    assign ch6         = ch_q[6];
    assign ch7         = ch_q[7];

endmodule

// File: tb/tb_adc_soc_frame_unpack.sv
// tb_adc_soc_frame_unpack
// Three unpackers (24-, 16- and 32-bit samples) share one stimulus stream.
// A predictor queues the expected frame per accepted input; a monitor on the
// falling edge pops and compares whenever out_valid is seen, and otherwise
// requires the outputs to hold (or to be zero while in reset).

module tb_adc_soc_frame_unpack;

    localparam int WPF  = 10;
    localparam int NDUT = 3;
    localparam int BPW [NDUT] = '{24, 16, 32};

    typedef logic [WPF-1:0][31:0] frame_t;

    typedef struct packed {
        logic [31:0]      status;
        logic [7:0][31:0] ch;
    } exp_t;

    typedef exp_t [NDUT-1:0] exp3_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   frame_valid = 1'b0;
    frame_t frame = '0;

    logic        o_valid  [NDUT];
    logic [31:0] o_status [NDUT];
    logic [31:0] o_ch     [NDUT][8];

    int n_checks = 0;
    int n_fail   = 0;

    exp3_t exp_q [$];
    exp3_t last_exp = '0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        adc_soc_frame_unpack #(
            .BITS_PER_WORD  (BPW[d]),
            .WORDS_PER_FRAME(WPF)
        ) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .frame_valid       (frame_valid),
            .frame_words_packed(frame),
            .out_valid         (o_valid[d]),
            .status_word       (o_status[d]),
            .ch0               (o_ch[d][0]),
            .ch1               (o_ch[d][1]),
            .ch2               (o_ch[d][2]),
            .ch3               (o_ch[d][3]),
            .ch4               (o_ch[d][4]),
            .ch5               (o_ch[d][5]),
            .ch6               (o_ch[d][6]),
            .ch7               (o_ch[d][7])
        );
    end

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d (bpw=%0d): got %h expected %h", name, d, BPW[d], act, exp);
        end
    endtask

    // Reference: keep the low bpw bits as a two's complement number.
    function automatic logic [31:0] sext(input logic [31:0] w, input int bpw);
        longint m;
        longint v;
        m = longint'(1) << bpw;
        v = longint'(w) & (m - 1);
        if (v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic exp3_t model(input frame_t f);
        exp3_t e;
        for (int d = 0; d < NDUT; d++) begin
            e[d].status = f[0];
            for (int c = 0; c < 8; c++) e[d].ch[c] = sext(f[c+1], BPW[d]);
        end
        return e;
    endfunction

    // Predictor: every accepted frame becomes one expected output set.
    always @(posedge clk) begin
        if (rst_n && frame_valid) exp_q.push_back(model(frame));
    end

    // Monitor: compare on out_valid, otherwise require hold or reset zeros.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_exp = '0;
            for (int d = 0; d < NDUT; d++) begin
                check("rst_valid", d, 32'(o_valid[d]), 32'd0);
                check("rst_status", d, o_status[d], 32'd0);
                for (int c = 0; c < 8; c++) check("rst_ch", d, o_ch[d][c], 32'd0);
            end
        end else if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                check("valid_pulse", d, 32'(o_valid[d]), 32'd1);
                check("status", d, o_status[d], last_exp[d].status);
                for (int c = 0; c < 8; c++) check("ch", d, o_ch[d][c], last_exp[d].ch[c]);
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                check("idle_valid", d, 32'(o_valid[d]), 32'd0);
                check("hold_status", d, o_status[d], last_exp[d].status);
                for (int c = 0; c < 8; c++) check("hold_ch", d, o_ch[d][c], last_exp[d].ch[c]);
            end
        end
    end

    // Present a frame for one edge; returns 1 time unit after that edge.
    task automatic drive(input frame_t f, input logic v);
        frame       = f;
        frame_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < WPF; k++) f[k] = $urandom;
        return f;
    endfunction

    initial begin
        frame_t f;

        // Reset held with a valid frame present: monitor demands all zeros.
        f    = '0;
        f[0] = 32'hA5A55A5A;
        f[1] = 32'h00000001; f[2] = 32'h00007FFF; f[3] = 32'h00008000; f[4] = 32'h0000FFFF;
        f[5] = 32'h00800000; f[6] = 32'h00FFFFFF; f[7] = 32'h00900000; f[8] = 32'h00000000;
        f[9] = 32'h13572468;
        frame       = f;
        frame_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic unpack: first edge after deassertion loads the frame.
        drive(f, 1'b1);
        check("basic_status", 0, o_status[0], 32'hA5A55A5A);
        check("basic_ch3", 0, o_ch[0][3], 32'h0000FFFF);
        check("basic_ch4", 0, o_ch[0][4], 32'hFF800000);
        check("basic_ch5", 0, o_ch[0][5], 32'hFFFFFFFF);
        check("basic_ch6", 0, o_ch[0][6], 32'hFF900000);
        check("basic_ch7", 0, o_ch[0][7], 32'h00000000);
        drive(rand_frame(), 1'b0);

        // Upper-bit masking and spare word ignored.
        f    = rand_frame();
        f[1] = 32'hAB7FFFFF;
        f[2] = 32'h12800000;
        f[9] = 32'hDEADBEEF;
        drive(f, 1'b1);
        check("mask_ch0", 0, o_ch[0][0], 32'h007FFFFF);
        check("mask_ch1", 0, o_ch[0][1], 32'hFF800000);

        // Hold: input churns with frame_valid low.
        repeat (5) drive(rand_frame(), 1'b0);

        // Back-to-back frames with ch0 = 1, 2, 3.
        for (int i = 1; i <= 3; i++) begin
            f    = rand_frame();
            f[1] = 32'(i);
            drive(f, 1'b1);
            check("b2b_valid", 0, 32'(o_valid[0]), 32'd1);
            check("b2b_ch0", 0, o_ch[0][0], 32'(i));
        end
        drive(rand_frame(), 1'b0);

        // Width sweep boundaries.
        f    = rand_frame();
        f[1] = 32'h00008000;
        drive(f, 1'b1);
        check("bpw16_ch0", 1, o_ch[1][0], 32'hFFFF8000);
        f[1] = 32'h80000000;
        drive(f, 1'b1);
        check("bpw32_ch0", 2, o_ch[2][0], 32'h80000000);
        drive(rand_frame(), 1'b0);

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        drive(rand_frame(), 1'b1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("async_rst_valid", d, 32'(o_valid[d]), 32'd0);
            check("async_rst_ch0", d, o_ch[d][0], 32'd0);
            check("async_rst_status", d, o_status[d], 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            drive(rand_frame(), ($urandom_range(0, 9) < 7));
        end

        drive(rand_frame(), 1'b0);
        drive(rand_frame(), 1'b0);
        @(negedge clk);
        #1;
        check("drain", 0, 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
